// File: rtl/accel_pwm_filter.sv
// accel_pwm_filter: moving-average smoothing of IMU X acceleration mapped to a clamped PWM duty.
module accel_pwm_filter #(
  parameter int LOG2_TAPS = 3,
  parameter int OFFSET    = 512,
  parameter int DUTY_MAX  = 1000
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic signed [9:0] AccelX,
  input  logic              ReadDone,
  output logic [9:0]        PWMinput,
  output logic              PWMValid,
  output logic              Primed,
  output logic              Overrun
);
  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW   = 10 + LOG2_TAPS;
  localparam int CW   = LOG2_TAPS + 1;
  localparam logic [9:0] RST_DUTY = 10'(OFFSET < 0 ? 0 : OFFSET > DUTY_MAX ? DUTY_MAX : OFFSET);
  typedef enum logic [1:0] {IDLE, UPDATE, SCALE, OUTPUT} state_t;
  state_t                state_q, state_d;
  logic                  rd_q, rd_d, rise;
  logic signed [9:0]     sample_q, sample_d;
  logic signed [9:0]     taps_q [TAPS];
  logic signed [9:0]     taps_d [TAPS];
  logic signed [SW-1:0]  sum_q, sum_d;
  logic [LOG2_TAPS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  primed_q, primed_d, overrun_q, overrun_d, valid_q, valid_d;
  logic [9:0]            duty_q, duty_d, pwm_q, pwm_d;
  logic signed [9:0]     avg;
  logic signed [11:0]    raw;
  always_comb begin
    rise      = ReadDone & ~rd_q;
    rd_d      = ReadDone;
    state_d   = state_q;
    sample_d  = sample_q;
    taps_d    = taps_q;
    sum_d     = sum_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    primed_d  = primed_q;
    duty_d    = duty_q;
    pwm_d     = pwm_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (rise && state_q != IDLE);
    // floor division by TAPS; unfilled taps are zero so the divisor never changes
    avg       = 10'(sum_q >>> LOG2_TAPS);
    raw       = 12'(avg) + 12'(OFFSET);
    unique case (state_q)
      IDLE: begin
        sample_d = rise ? AccelX : sample_q;
        state_d  = rise ? UPDATE : IDLE;
      end
      UPDATE: begin
        sum_d            = sum_q - SW'(taps_q[wr_ptr_q]) + SW'(sample_q);
        taps_d[wr_ptr_q] = sample_q;
        wr_ptr_d         = wr_ptr_q + 1'b1;
        count_d          = count_q == CW'(TAPS) ? count_q : count_q + 1'b1;
        primed_d         = primed_q | (count_d == CW'(TAPS));
        state_d          = SCALE;
      end
      SCALE: begin
        duty_d  = raw[11] ? '0 : raw > 12'(DUTY_MAX) ? 10'(DUTY_MAX) : raw[9:0];
        state_d = OUTPUT;
      end
      default: begin
        pwm_d   = duty_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      sample_q  <= '0;
      taps_q    <= '{default: '0};
      sum_q     <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      primed_q  <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      duty_q    <= RST_DUTY;
      pwm_q     <= RST_DUTY;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      sample_q  <= sample_d;
      taps_q    <= taps_d;
      sum_q     <= sum_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      primed_q  <= primed_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
    end
  end
  assign PWMinput = pwm_q;
  assign PWMValid = valid_q;
  assign Primed   = primed_q;
  assign Overrun  = overrun_q;
endmodule

// File: tb/tb_accel_pwm_filter.sv
// tb_accel_pwm_filter: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_accel_pwm_filter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd = 1'b0;
  logic [9:0] ax = '0;
  logic [9:0] pwm;
  logic       pwm_valid, primed, overrun;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  typedef struct {logic [9:0] duty; int at;} exp_t;
  exp_t       sb[$];
  exp_t       e;
  int         p511[8] = '{127, 255, 383, 511, 639, 767, 895, 1000};
  int         p100[8] = '{524, 537, 549, 562, 574, 587, 599, 612};
  int         m100[8] = '{587, 562, 537, 512, 487, 462, 437, 412};

  accel_pwm_filter dut (
    .CLOCK_50(clk),
    .RESET(rst),
    .AccelX(ax),
    .ReadDone(rd),
    .PWMinput(pwm),
    .PWMValid(pwm_valid),
    .Primed(primed),
    .Overrun(overrun)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pwm_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid: got PWMValid=1 PWMinput=%0d at cycle %0d, want no pulse", pwm, cyc);
      end else begin
        e = sb.pop_front();
        check("duty", int'(pwm), int'(e.duty));
        check("latency_cycle", cyc, e.at);
      end
    end
  end

  task automatic send(input logic [9:0] a, input int exp);
    @(negedge clk);
    ax = a;
    rd = 1'b1;
    sb.push_back('{10'(exp), cyc + 4});
    @(negedge clk);
    rd = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_pwm", int'(pwm), 512);
    check("reset_valid", int'(pwm_valid), 0);
    check("reset_primed", int'(primed), 0);
    check("reset_overrun", int'(overrun), 0);
    repeat (10) @(negedge clk);
    check("idle_pwm_hold", int'(pwm), 512);

    send(10'd80, 522);
    repeat (2) @(negedge clk);
    check("single_not_primed", int'(primed), 0);
    check("single_pwm_hold", int'(pwm), 522);

    do_reset();
    for (int i = 0; i < 7; i++) send(10'h200, 448 - 64 * i);
    check("primed_before_8th", int'(primed), 0);
    @(negedge clk);
    ax = 10'h200;
    rd = 1'b1;
    sb.push_back('{10'd0, cyc + 4});
    @(negedge clk);
    check("primed_at_detect", int'(primed), 0);
    rd = 1'b0;
    @(negedge clk);
    check("primed_at_update", int'(primed), 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) send(10'd511, p511[i]);

    do_reset();
    for (int i = 0; i < 8; i++) send(10'd100, p100[i]);
    for (int i = 0; i < 8; i++) send(10'(-100), m100[i]);
    check("wrap_primed", int'(primed), 1);
    check("wrap_pwm", int'(pwm), 412);

    @(negedge clk);
    ax = 10'd80;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midreset_pwm", int'(pwm), 512);
    check("midreset_primed", int'(primed), 0);
    check("midreset_overrun", int'(overrun), 0);
    send(10'd80, 522);

    do_reset();
    check("overrun_clear", int'(overrun), 0);
    @(negedge clk);
    ax = 10'd80;
    rd = 1'b1;
    sb.push_back('{10'd522, cyc + 4});
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    ax = 10'h200;
    rd = 1'b1;
    repeat (10) @(negedge clk);
    check("overrun_set", int'(overrun), 1);
    check("overrun_result", int'(pwm), 522);
    rd = 1'b0;
    @(negedge clk);
    ax = 10'd160;
    rd = 1'b1;
    sb.push_back('{10'd542, cyc + 4});
    repeat (20) @(negedge clk);
    rd = 1'b0;
    repeat (3) @(negedge clk);
    check("overrun_sticky", int'(overrun), 1);
    check("held_level_pwm", int'(pwm), 542);

    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
